multicycle_ctrl: RTL and testbench

- Multi-cycle main controller for the MIPS core; successor to the combinational opcode decoder and ALU-control pair.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Performs a req/ready handshake with the unified memory, with a parametrised wait-state timeout.
- Folds R-type funct decode and I-type ALU selection into one registered ALU-op output; adds BEQ and J.

---
 rtl/multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// req/ready handshake with wait-state timeout, and registered ALU/mux decode.
module multicycle_ctrl #(
  parameter int ALUOP_W = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src,
  output logic               imm_ext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_ALU = 3'd0,
    K_LW  = 3'd1,
    K_SW  = 3'd2,
    K_BEQ = 3'd3,
    K_J   = 3'd4
  } kind_t;

  // Shared ALU operation encodings
  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALUOP_ADDU = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALUOP_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALUOP_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALUOP_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALUOP_SLT  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALUOP_LUI  = ALUOP_W'(7);

  localparam logic [1:0] SEL_REGDST_RT  = 2'd0;
  localparam logic [1:0] SEL_REGDST_RD  = 2'd1;
  localparam logic [1:0] SEL_WB_ALUOUT  = 2'd0;
  localparam logic [1:0] SEL_WB_DM      = 2'd1;
  localparam logic       SEL_ALUSRC_REG = 1'b0;
  localparam logic       SEL_ALUSRC_IMM = 1'b1;
  localparam logic       EXT_MODE_SIGNED   = 1'b0;
  localparam logic       EXT_MODE_UNSIGNED = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Last wait count before giving up; mem_ready on that cycle still succeeds.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  kind_t              kind_q;

  logic [ALUOP_W-1:0] dec_aop;
  logic [1:0]         dec_rd;
  logic [1:0]         dec_m2r;
  logic               dec_as;
  logic               dec_ie;
  kind_t              dec_kind;
  logic               dec_ok;

  // Combinational opcode/funct decode, sampled into registers in DECODE
  always_comb begin
    dec_aop  = ALUOP_ADD;
    dec_rd   = SEL_REGDST_RT;
    dec_m2r  = SEL_WB_ALUOUT;
    dec_as   = SEL_ALUSRC_REG;
    dec_ie   = EXT_MODE_SIGNED;
    dec_kind = K_ALU;
    dec_ok   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dec_rd = SEL_REGDST_RD;
        case (funct)
          6'b100000: dec_aop = ALUOP_ADD;
          6'b100001: dec_aop = ALUOP_ADDU;
          6'b100010: dec_aop = ALUOP_SUB;
          6'b100100: dec_aop = ALUOP_AND;
          6'b100101: dec_aop = ALUOP_OR;
          6'b100110: dec_aop = ALUOP_XOR;
          6'b101010: dec_aop = ALUOP_SLT;
          default:   dec_ok  = 1'b0;
        endcase
      end
      OP_ADDI:  begin dec_aop = ALUOP_ADD;  dec_as = SEL_ALUSRC_IMM; end
      OP_ADDIU: begin dec_aop = ALUOP_ADDU; dec_as = SEL_ALUSRC_IMM; end
      OP_ANDI:  begin dec_aop = ALUOP_AND;  dec_as = SEL_ALUSRC_IMM; dec_ie = EXT_MODE_UNSIGNED; end
      OP_ORI:   begin dec_aop = ALUOP_OR;   dec_as = SEL_ALUSRC_IMM; dec_ie = EXT_MODE_UNSIGNED; end
      OP_XORI:  begin dec_aop = ALUOP_XOR;  dec_as = SEL_ALUSRC_IMM; dec_ie = EXT_MODE_UNSIGNED; end
      OP_LUI:   begin dec_aop = ALUOP_LUI;  dec_as = SEL_ALUSRC_IMM; dec_ie = EXT_MODE_UNSIGNED; end
      OP_LW:    begin dec_as = SEL_ALUSRC_IMM; dec_m2r = SEL_WB_DM; dec_kind = K_LW; end
      OP_SW:    begin dec_as = SEL_ALUSRC_IMM; dec_kind = K_SW; end
      OP_BEQ:   begin dec_aop = ALUOP_SUB; dec_kind = K_BEQ; end
      OP_J:     dec_kind = K_J;
      default:  dec_ok = 1'b0;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded control set, captured on the DECODE edge and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op     <= ALUOP_ADD;
      reg_dst    <= SEL_REGDST_RT;
      mem_to_reg <= SEL_WB_ALUOUT;
      alu_src    <= SEL_ALUSRC_REG;
      imm_ext    <= EXT_MODE_SIGNED;
      kind_q     <= K_ALU;
    end else if (state_q == S_DECODE) begin
      alu_op     <= dec_aop;
      reg_dst    <= dec_rd;
      mem_to_reg <= dec_m2r;
      alu_src    <= dec_as;
      imm_ext    <= dec_ie;
      kind_q     <= dec_kind;
    end
  end

  // Next-state, wait counting and pulse/request outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          cnt_d    = '0;
          state_d  = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = dec_ok ? S_EXEC : S_FAULT;
      S_EXEC: begin
        case (kind_q)
          K_BEQ: begin
            pc_write = alu_zero;
            pc_src   = 2'b01;
            state_d  = S_FETCH;
          end
          K_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
          end
          K_LW, K_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (kind_q == K_SW);
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = (kind_q == K_SW) ? S_FETCH : S_WB;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    // Reset is asynchronous: outputs must drop in the same cycle, not at the next edge
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      reg_write = 1'b0;
    end
  end

  assign state = state_q;
  assign fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_multicycle_ctrl;

  localparam logic [2:0] K_ALU = 3'd0, K_LW = 3'd1, K_SW = 3'd2, K_BEQ = 3'd3, K_J = 3'd4;

  typedef struct packed {
    logic [4:0] aop;
    logic [1:0] rd;
    logic       as;
    logic       ie;
    logic [1:0] m2r;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic        irw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        rw;
    logic        we;
    logic        flt;
    ctrl_t       c;
  } snap_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] kind;
    logic       zero;
    logic [7:0] fw;
    logic [7:0] mw;
    logic       pcw;
    logic [1:0] pcs;
    logic       we;
    ctrl_t      c;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic       alu_src, imm_ext, fault;
  logic [4:0] alu_op;
  logic [2:0] state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  snap_t       q[$];
  ctrl_t       prev;
  logic        fault_d = 1'b0;
  vec_t        vecs[$];

  multicycle_ctrl #(.ALUOP_W(5), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .imm_ext(imm_ext),
    .alu_op(alu_op), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic snap_t mksnap(input int unsigned c, input logic [2:0] st,
                                   input logic irw, input logic pcw, input logic [1:0] pcs,
                                   input logic rw, input logic we, input logic flt,
                                   input ctrl_t cc);
    snap_t s;
    s.cyc = c; s.st = st; s.irw = irw; s.pcw = pcw; s.pcs = pcs;
    s.rw = rw; s.we = we; s.flt = flt; s.c = cc;
    return s;
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] kind,
                              input logic zero, input logic [7:0] fw, input logic [7:0] mw,
                              input logic pcw, input logic [1:0] pcs, input logic we,
                              input logic [4:0] aop, input logic [1:0] rd, input logic as,
                              input logic ie, input logic [1:0] m2r);
    vec_t v;
    v.op = op; v.fn = fn; v.kind = kind; v.zero = zero; v.fw = fw; v.mw = mw;
    v.pcw = pcw; v.pcs = pcs; v.we = we;
    v.c.aop = aop; v.c.rd = rd; v.c.as = as; v.c.ie = ie; v.c.m2r = m2r;
    return v;
  endfunction

  // Monitor: an event is any pulse, a completed memory handshake, an EXEC cycle or fault onset
  always @(negedge clk) begin
    snap_t act, exp;
    if (!rst_n) begin
      fault_d = 1'b0;
    end else begin
      if (ir_write | pc_write | reg_write | (mem_req & mem_ready) | (state == 3'd2) | (fault & ~fault_d)) begin
        act = mksnap(cyc, state, ir_write, pc_write, pc_src, reg_write, mem_we, fault,
                     {alu_op, reg_dst, alu_src, imm_ext, mem_to_reg});
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got %0h want none", act);
        end else begin
          exp = q.pop_front();
          if (exp.flt) begin
            act.c = '0;
            exp.c = '0;
          end
          check("event", 64'(act), 64'(exp));
        end
      end
      fault_d = fault;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one legal instruction from its first FETCH cycle; returns at the next FETCH cycle
  task automatic run_vec(input vec_t v);
    int unsigned t0, te;
    t0 = cyc;
    opcode = v.op; funct = v.fn; alu_zero = v.zero; mem_ready = 1'b0;
    q.push_back(mksnap(t0 + v.fw, 3'd0, 1, 1, 2'b00, 0, 0, 0, prev));
    repeat (v.fw) step();
    mem_ready = 1'b1;
    step();
    step();                       // DECODE: mem_ready still high, must be ignored
    mem_ready = 1'b0;
    te = t0 + v.fw + 2;
    q.push_back(mksnap(te, 3'd2, 0, v.pcw, v.pcs, 0, 0, 0, v.c));
    step();
    if (v.kind == K_LW || v.kind == K_SW) begin
      q.push_back(mksnap(te + 1 + v.mw, 3'd3, 0, 0, 2'b00, 0, v.we, 0, v.c));
      for (int i = 0; i < int'(v.mw); i++) begin
        @(negedge clk);
        check("mem_wait_req_we", {mem_req, mem_we}, {1'b1, v.we});
        @(posedge clk);
        #1;
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      if (v.kind == K_LW) begin
        q.push_back(mksnap(te + 2 + v.mw, 3'd4, 0, 0, 2'b00, 1, 0, 0, v.c));
        step();
      end
    end else if (v.kind == K_ALU) begin
      q.push_back(mksnap(te + 1, 3'd4, 0, 0, 2'b00, 1, 0, 0, v.c));
      step();
    end
    prev = v.c;
  endtask

  // Holds the DUT in FAULT with mem_ready toggling, then resets it
  task automatic hold_fault_and_reset(input string nm);
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      @(negedge clk);
      check(nm, {fault, state, mem_req, ir_write, pc_write, reg_write},
                {1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check({nm, "_reset"}, {fault, state, mem_req}, {1'b0, 3'd0, 1'b0});
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev = '0;
  endtask

  task automatic fault_illegal(input logic [5:0] op, input logic [5:0] fn, input string nm);
    int unsigned t0;
    t0 = cyc;
    opcode = op; funct = fn; mem_ready = 1'b1;
    q.push_back(mksnap(t0, 3'd0, 1, 1, 2'b00, 0, 0, 0, prev));
    q.push_back(mksnap(t0 + 2, 3'd7, 0, 0, 2'b00, 0, 0, 1, '0));
    step();
    mem_ready = 1'b0;
    step();
    step();
    hold_fault_and_reset(nm);
  endtask

  task automatic fault_timeout();
    int unsigned t0;
    t0 = cyc;
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b0;
    q.push_back(mksnap(t0 + 16, 3'd7, 0, 0, 2'b00, 0, 0, 1, '0));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("fetch_wait_req", {mem_req, state}, {1'b1, 3'd0});
      @(posedge clk);
      #1;
    end
    hold_fault_and_reset("fetch_timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    prev = '0;
    //                op     fn     kind   z fw  mw  pcw pcs we aop rd as ie m2r
    vecs.push_back(mk(6'h00, 6'h20, K_ALU, 0, 0,  0, 0, 2'd0, 0, 0, 1, 0, 0, 0)); // ADD
    vecs.push_back(mk(6'h00, 6'h22, K_ALU, 0, 2,  0, 0, 2'd0, 0, 2, 1, 0, 0, 0)); // SUB
    vecs.push_back(mk(6'h00, 6'h2A, K_ALU, 0, 0,  0, 0, 2'd0, 0, 6, 1, 0, 0, 0)); // SLT
    vecs.push_back(mk(6'h00, 6'h24, K_ALU, 0, 1,  0, 0, 2'd0, 0, 3, 1, 0, 0, 0)); // AND
    vecs.push_back(mk(6'h0D, 6'h15, K_ALU, 0, 0,  0, 0, 2'd0, 0, 4, 0, 1, 1, 0)); // ORI
    vecs.push_back(mk(6'h08, 6'h00, K_ALU, 0, 0,  0, 0, 2'd0, 0, 0, 0, 1, 0, 0)); // ADDI
    vecs.push_back(mk(6'h09, 6'h3F, K_ALU, 0, 0,  0, 0, 2'd0, 0, 1, 0, 1, 0, 0)); // ADDIU
    vecs.push_back(mk(6'h0F, 6'h00, K_ALU, 0, 0,  0, 0, 2'd0, 0, 7, 0, 1, 1, 0)); // LUI
    vecs.push_back(mk(6'h23, 6'h00, K_LW,  0, 0,  3, 0, 2'd0, 0, 0, 0, 1, 0, 1)); // LW, 3 waits
    vecs.push_back(mk(6'h2B, 6'h00, K_SW,  0, 1,  1, 0, 2'd0, 1, 0, 0, 1, 0, 0)); // SW
    vecs.push_back(mk(6'h04, 6'h00, K_BEQ, 1, 0,  0, 1, 2'd1, 0, 2, 0, 0, 0, 0)); // BEQ taken
    vecs.push_back(mk(6'h04, 6'h00, K_BEQ, 0, 0,  0, 0, 2'd1, 0, 2, 0, 0, 0, 0)); // BEQ not taken
    vecs.push_back(mk(6'h02, 6'h00, K_J,   0, 0,  0, 1, 2'd2, 0, 0, 0, 0, 0, 0)); // J
    vecs.push_back(mk(6'h00, 6'h26, K_ALU, 0, 15, 0, 0, 2'd0, 0, 5, 1, 0, 0, 0)); // XOR, ready on last wait
    vecs.push_back(mk(6'h23, 6'h00, K_LW,  0, 0, 15, 0, 2'd0, 0, 0, 0, 1, 0, 1)); // LW, ready on last wait
    vecs.push_back(mk(6'h0E, 6'h00, K_ALU, 0, 0,  0, 0, 2'd0, 0, 5, 0, 1, 1, 0)); // XORI

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {state, fault, mem_req, ir_write, pc_write, reg_write, alu_op},
                         {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-FETCH while mem_req is up
    repeat (3) step();
    @(negedge clk);
    check("fetch_req_before_reset", {mem_req, state}, {1'b1, 3'd0});
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset_mid_fetch", {mem_req, ir_write, pc_write, state, fault},
                             {1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    fault_illegal(6'h3F, 6'h20, "illegal_opcode");
    fault_illegal(6'h00, 6'h3F, "illegal_funct");
    fault_timeout();

    run_vec(vecs[0]);
    repeat (3) step();
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
